block_output: RTL and testbench
===============================

// Module: block_output
// PURPOSE
// - Output stage of one router port; sits directly downstream of the five block_input instances.
// - Collects the per-input requests raised by each input's route decode ("register" bit for this port).
// - Picks one requester round-robin and pops its head flit through a one-cycle grant.
// - Registers the flit and drives it to the neighbour router with the val/ret link handshake.
// PARAMETERS
// - DATA_WIDTH  8  flit width in bits; equals block_input DATA_WIDTH.
// - N_PORT      5  number of competing input ports (local, N, E, S, W).
// - N_PTR       3  width of the round-robin pointer; must satisfy 2**N_PTR >= N_PORT.
// PORTS
// - clk      in   1                    single clock; all state updates on its rising edge.
// - rst      in   1                    asynchronous reset, active-low; state clears on the falling edge of rst.
// - req      in   N_PORT               req[i]=1: input i holds a head flit routed to this port.
// - Data_in  in   N_PORT*DATA_WIDTH    input i flit on bits [i*DATA_WIDTH +: DATA_WIDTH]; valid whenever req[i]=1.
// - gnt      out  N_PORT               one-hot pop strobe to input i; at most one bit set; combinational.
// - ret      in   1                    from the neighbour: 1 = neighbour buffer full, hold the flit.
// - val      out  1                    to the neighbour: Data_out holds a valid flit.
// - Data_out out  DATA_WIDTH           registered flit toward the neighbour.
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - val=0, Data_out=0, rr pointer=0.
//   - gnt=0 while rst=0.
// - Link transfer: a flit moves to the neighbour on every rising edge where val=1 and ret=0.
// - Hold: while val=1 and ret=1, val and Data_out stay stable.
// - Output-register state:
//   - slot_free = (val==0) || (ret==0).
//   - EMPTY (val=0): accepts a flit.
//   - FULL (val=1): accepts a new flit only in the same cycle the current flit transfers.
// - Arbitration (combinational, same cycle):
//   - When slot_free and |req, the arbiter searches req from index ptr upward, wrapping modulo N_PORT.
//   - The first set bit, w, wins and gnt[w]=1.
//   - gnt=0 when req=0 or slot_free=0; inputs never pop while the link is stalled.
// - Capture: on the edge with gnt[w]=1:
//   - Data_out <= Data_in[w].
//   - val <= 1.
//   - ptr <= (w==N_PORT-1) ? 0 : w+1.
// - Drain: on an edge with a transfer and no grant, val <= 0 and Data_out holds its last value.
// - Latency and throughput:
//   - req seen at cycle t gives gnt at t; the flit appears on Data_out at t+1.
//   - Throughput is 1 flit/cycle back-to-back while ret=0.
// - Fairness: a continuously requesting input is granted within N_PORT grants.
// - Pointer: ptr changes only on a grant; it is never >= N_PORT.
// - Simultaneous transfer and grant: the new flit replaces the old one in the same edge; val stays 1, with no bubble.
// - ret toggling with val=0 has no effect.
// - req[i] dropping mid-stall: no grant is issued, so nothing is lost.
// - Reset mid-transfer: the held flit is discarded; val=0 immediately, asynchronously.
// STRUCTURE
// - Shared package/header (noc_params):
//   - DATA_WIDTH, N_PORT, N_PTR.
//   - Port index constants: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
// - Sub-module rr_arbiter:
//   - Inputs: req, en(=slot_free), ptr.
//   - Outputs: one-hot gnt and binary winner index.
//   - Purely combinational; ptr register and output register live in block_output.
// - block_output contains:
//   - the rr_arbiter instance;
//   - the N_PORT:1 data mux selected by winner;
//   - the ptr register and the val/Data_out register.
// TESTING
// - Reset: hold rst=0 with req=5'b11111.
//   - Required: val=0, Data_out=0, gnt=0.
//   - After release, the first grant goes to port 0.
// - Round robin: req=5'b11111 constant, ret=0, Data_in[i]=8'hA0+i.
//   - Required: gnt sequence 0,1,2,3,4,0,...
//   - Required: Data_out sequence A0,A1,A2,A3,A4; val stays 1 with no gaps.
// - Back-pressure: grant a flit 8'h5C, then hold ret=1 for 4 cycles.
//   - Required: val=1, Data_out=5C stable and gnt=0 throughout.
//   - Required: on the ret=0 edge, 5C transfers and the next grant fires in that same cycle.
// - Wrap and skip: ptr=3, req=5'b00101.
//   - Required: gnt=5'b00001 (port 0) and ptr becomes 1.
//   - Then gnt=5'b00100 (port 2) and ptr becomes 3.
// - Drain: a single flit 8'h11 from port 4, then req=0, ret=0.
//   - Required: val=1 for exactly one cycle with Data_out=11.
//   - Then val=0, and Data_out holds 11.
// - Async reset mid-stall: val=1, ret=1, rst falls between clock edges.
//   - Required: val=0 before the next clock edge.
//   - Required: after release, ptr=0 and no flit is re-sent.

Source files
------------

// File: rtl/block_output_pkg.sv
// Shared router parameters and types for the output stage of one router port.
package block_output_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int N_PORT     = 5;
    localparam int N_PTR      = 3;

    // Input port indices in the order the arbiter scans them.
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef logic [N_PTR-1:0]      ptr_t;
    typedef logic [DATA_WIDTH-1:0] flit_t;
    typedef logic [N_PORT-1:0]     port_vec_t;
endpackage

// File: rtl/block_output_if.sv
// Bundle of the request/pop side (towards the block_input instances) and the
// val/ret link side (towards the neighbour router) of one output port.
interface block_output_if;
    import block_output_pkg::*;

    port_vec_t                    req;
    logic [N_PORT*DATA_WIDTH-1:0] Data_in;
    port_vec_t                    gnt;
    logic                         ret;
    logic                         val;
    flit_t                        Data_out;

    // master: the environment (inputs plus neighbour); slave: the output stage.
    modport master (output req, Data_in, ret, input gnt, val, Data_out);
    modport slave  (input req, Data_in, ret, output gnt, val, Data_out);
endinterface

// File: rtl/block_output_rr_arbiter.sv
// Combinational round-robin arbiter: scans req from ptr upward, wrapping
// modulo N_PORT, and grants the first requester while en is high.
module block_output_rr_arbiter
    import block_output_pkg::*;
(
    input  port_vec_t req_i,
    input  logic      en_i,
    input  ptr_t      ptr_i,
    output port_vec_t gnt_o,
    output ptr_t      winner_o,
    output logic      valid_o
);
    localparam logic [N_PTR:0] N_PORT_W = (N_PTR+1)'(N_PORT);

    logic [N_PTR:0] sum  [N_PORT];
    ptr_t           cand [N_PORT];

    // cand[gi] is the port index visited at scan position gi; ptr is always
    // below N_PORT, so a single subtraction is enough to wrap.
    for (genvar gi = 0; gi < N_PORT; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr_i} + (N_PTR+1)'(gi);
        assign cand[gi] = (sum[gi] >= N_PORT_W) ? N_PTR'(sum[gi] - N_PORT_W)
                                                 : sum[gi][N_PTR-1:0];
    end

    // Priority pick in scan order: the first requesting candidate wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = 0; k < N_PORT; k++) begin
            if (en_i && !valid_o && req_i[cand[k]]) begin
                valid_o  = 1'b1;
                winner_o = cand[k];
            end
        end
    end

    for (genvar gi = 0; gi < N_PORT; gi++) begin : g_gnt
        assign gnt_o[gi] = valid_o && (winner_o == N_PTR'(gi));
    end
endmodule

// File: rtl/block_output.sv
// Output stage of one router port: arbitrates the five inputs round-robin,
// pops the winner's head flit and drives it over the val/ret link.
module block_output
    import block_output_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    block_output_if.slave  bus
);
    flit_t     flit [N_PORT];
    port_vec_t gnt_w;
    ptr_t      winner;
    logic      grant;
    logic      slot_free;
    logic      transfer;

    logic  val_q,  val_d;
    flit_t data_q, data_d;
    ptr_t  ptr_q,  ptr_d;

    for (genvar gi = 0; gi < N_PORT; gi++) begin : g_flit
        assign flit[gi] = bus.Data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // The slot can take a flit when empty or when the current one leaves this
    // edge; grants are suppressed during reset so no input pops a flit then.
    assign transfer  = val_q && !bus.ret;
    assign slot_free = rst && (!val_q || !bus.ret);

    block_output_rr_arbiter u_arb (
        .req_i    (bus.req),
        .en_i     (slot_free),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt_w),
        .winner_o (winner),
        .valid_o  (grant)
    );

    assign bus.gnt      = gnt_w;
    assign bus.val      = val_q;
    assign bus.Data_out = data_q;

    // Next state: a grant loads the winner's flit (replacing one that leaves
    // the same edge), a transfer without a grant drains the slot.
    always_comb begin
        val_d  = val_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (grant) begin
            val_d  = 1'b1;
            data_d = flit[winner];
            ptr_d  = (winner == N_PTR'(N_PORT-1)) ? '0 : winner + N_PTR'(1);
        end else if (transfer) begin
            val_d = 1'b0;
        end
    end

    // Output register and round-robin pointer, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q  <= 1'b0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end
endmodule

// File: tb/tb_block_output.sv
// Self-checking bench for block_output: directed scenarios plus random
// traffic compared against a round-robin model of the output port.
module tb_block_output;
    localparam int N  = 5;
    localparam int DW = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Reference model state.
    int       ptr_m;
    bit       val_m;
    logic [7:0] data_m;

    block_output_if bus_if ();

    block_output dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Expected grant: first requester at or after ptr, modulo N, when the
    // output slot can accept a flit.
    function automatic logic [4:0] exp_gnt();
        logic [4:0] g;
        int         w;
        bit         done;
        g    = '0;
        done = 1'b0;
        if (rst && (!val_m || !bus_if.ret)) begin
            for (int k = 0; k < N; k++) begin
                w = (ptr_m + k) % N;
                if (!done && bus_if.req[w]) begin
                    g[w] = 1'b1;
                    done = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // Advance one clock edge and update the model with what that edge does.
    task automatic tick();
        logic [4:0] g;
        g = exp_gnt();
        @(posedge clk);
        if (g != '0) begin
            for (int w = 0; w < N; w++) begin
                if (g[w]) begin
                    data_m = bus_if.Data_in[w*DW +: DW];
                    ptr_m  = (w + 1) % N;
                end
            end
            val_m = 1'b1;
        end else if (val_m && !bus_if.ret) begin
            val_m = 1'b0;
        end
        #1;
    endtask

    task automatic set_din(input int p, input logic [7:0] v);
        bus_if.Data_in[p*DW +: DW] = v;
    endtask

    task automatic model_reset();
        ptr_m  = 0;
        val_m  = 1'b0;
        data_m = 8'h00;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus_if.req = 5'b11111;
        bus_if.ret = 1'b0;
        for (int i = 0; i < N; i++) set_din(i, 8'hA0 + 8'(i));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.val !== 1'b0) begin
            errors++; $display("FAIL reset_val: got %b want 0", bus_if.val);
        end
        checks++;
        if (bus_if.Data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", bus_if.Data_out);
        end
        checks++;
        if (bus_if.gnt !== 5'b00000) begin
            errors++; $display("FAIL reset_gnt: got %b want 00000", bus_if.gnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00001) begin
            errors++; $display("FAIL reset_first_gnt: got %b want 00001", bus_if.gnt);
        end
        $display("txn reset released, first grant %b", bus_if.gnt);
    endtask

    task automatic test_round_robin();
        logic [4:0] want;
        bus_if.req = 5'b11111;
        bus_if.ret = 1'b0;
        for (int n = 0; n < 10; n++) begin
            want = 5'b00001 << (n % N);
            checks++;
            if (bus_if.gnt !== want || want !== exp_gnt()) begin
                errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, bus_if.gnt, want);
            end
            tick();
            checks++;
            if (bus_if.val !== 1'b1 || bus_if.Data_out !== 8'hA0 + 8'(n % N)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got val=%b data=%h want val=1 data=%h",
                         n, bus_if.val, bus_if.Data_out, 8'hA0 + 8'(n % N));
            end
            $display("txn rr %0d gnt=%b data=%h", n, want, bus_if.Data_out);
            #1;
        end
    endtask

    task automatic test_back_pressure();
        bus_if.req = 5'b00100;
        bus_if.ret = 1'b0;
        set_din(2, 8'h5C);
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00100) begin
            errors++; $display("FAIL bp_first_gnt: got %b want 00100", bus_if.gnt);
        end
        tick();
        bus_if.ret = 1'b1;
        bus_if.req = 5'b11111;
        for (int i = 0; i < N; i++) if (i != 2) set_din(i, 8'h30 + 8'(i));
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus_if.gnt !== 5'b00000 || bus_if.val !== 1'b1 || bus_if.Data_out !== 8'h5C) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got gnt=%b val=%b data=%h want gnt=00000 val=1 data=5c",
                         c, bus_if.gnt, bus_if.val, bus_if.Data_out);
            end
            tick();
        end
        bus_if.ret = 1'b0;
        #1;
        checks++;
        if (bus_if.gnt !== 5'b01000) begin
            errors++; $display("FAIL bp_release_gnt: got %b want 01000", bus_if.gnt);
        end
        tick();
        checks++;
        if (bus_if.val !== 1'b1 || bus_if.Data_out !== 8'h33) begin
            errors++;
            $display("FAIL bp_next_flit: got val=%b data=%h want val=1 data=33", bus_if.val, bus_if.Data_out);
        end
        $display("txn back-pressure released, next flit %h", bus_if.Data_out);
    endtask

    task automatic test_wrap_skip();
        // ptr is 4 here; a lone grant to port 2 moves it to 3.
        bus_if.req = 5'b00100;
        set_din(0, 8'hC0);
        set_din(2, 8'hC2);
        #1;
        tick();
        bus_if.req = 5'b00101;
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00001) begin
            errors++; $display("FAIL wrap_gnt0: got %b want 00001", bus_if.gnt);
        end
        tick();
        checks++;
        if (bus_if.Data_out !== 8'hC0) begin
            errors++; $display("FAIL wrap_data0: got %h want c0", bus_if.Data_out);
        end
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00100) begin
            errors++; $display("FAIL wrap_gnt2: got %b want 00100 (ptr=1)", bus_if.gnt);
        end
        tick();
        bus_if.req = 5'b11111;
        #1;
        checks++;
        if (bus_if.gnt !== 5'b01000) begin
            errors++; $display("FAIL wrap_ptr3: got %b want 01000 (ptr=3)", bus_if.gnt);
        end
        tick();
        $display("txn wrap/skip done, data=%h", bus_if.Data_out);
    endtask

    task automatic test_drain();
        bus_if.req = 5'b10000;
        bus_if.ret = 1'b0;
        set_din(4, 8'h11);
        #1;
        checks++;
        if (bus_if.gnt !== 5'b10000) begin
            errors++; $display("FAIL drain_gnt: got %b want 10000", bus_if.gnt);
        end
        tick();
        bus_if.req = 5'b00000;
        checks++;
        if (bus_if.val !== 1'b1 || bus_if.Data_out !== 8'h11) begin
            errors++; $display("FAIL drain_flit: got val=%b data=%h want val=1 data=11", bus_if.val, bus_if.Data_out);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus_if.val !== 1'b0 || bus_if.Data_out !== 8'h11) begin
                errors++;
                $display("FAIL drain_empty[%0d]: got val=%b data=%h want val=0 data=11", c, bus_if.val, bus_if.Data_out);
            end
        end
        $display("txn drain done");
    endtask

    task automatic test_ret_idle_and_stall_drop();
        for (int c = 0; c < 4; c++) begin
            bus_if.ret = ~bus_if.ret;
            tick();
            checks++;
            if (bus_if.val !== 1'b0 || bus_if.Data_out !== 8'h11) begin
                errors++; $display("FAIL idle_ret[%0d]: got val=%b data=%h want val=0 data=11", c, bus_if.val, bus_if.Data_out);
            end
        end
        bus_if.ret = 1'b1;
        bus_if.req = 5'b00010;
        set_din(1, 8'h77);
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00010) begin
            errors++; $display("FAIL empty_ret_gnt: got %b want 00010", bus_if.gnt);
        end
        tick();
        bus_if.req = 5'b00000;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus_if.gnt !== 5'b00000 || bus_if.val !== 1'b1 || bus_if.Data_out !== 8'h77) begin
                errors++;
                $display("FAIL stall_drop[%0d]: got gnt=%b val=%b data=%h want gnt=00000 val=1 data=77",
                         c, bus_if.gnt, bus_if.val, bus_if.Data_out);
            end
            tick();
        end
        bus_if.ret = 1'b0;
        tick();
        checks++;
        if (bus_if.val !== 1'b0) begin
            errors++; $display("FAIL stall_drop_drain: got val=%b want 0", bus_if.val);
        end
        $display("txn stall with dropped request done");
    endtask

    task automatic test_async_reset();
        // ptr is 2; port 1 is reached by wrapping and leaves ptr at 2.
        bus_if.req = 5'b00010;
        bus_if.ret = 1'b0;
        set_din(1, 8'hE7);
        #1;
        tick();
        bus_if.req = 5'b00000;
        bus_if.ret = 1'b1;
        tick();
        checks++;
        if (bus_if.val !== 1'b1 || bus_if.Data_out !== 8'hE7) begin
            errors++; $display("FAIL areset_setup: got val=%b data=%h want val=1 data=e7", bus_if.val, bus_if.Data_out);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus_if.val !== 1'b0 || bus_if.Data_out !== 8'h00 || bus_if.gnt !== 5'b00000) begin
            errors++;
            $display("FAIL areset_immediate: got val=%b data=%h gnt=%b want val=0 data=00 gnt=00000",
                     bus_if.val, bus_if.Data_out, bus_if.gnt);
        end
        #2;
        rst = 1'b1;
        bus_if.ret = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus_if.val !== 1'b0) begin
                errors++; $display("FAIL areset_resend[%0d]: got val=%b want 0", c, bus_if.val);
            end
        end
        bus_if.req = 5'b11111;
        #1;
        checks++;
        if (bus_if.gnt !== 5'b00001) begin
            errors++; $display("FAIL areset_ptr: got %b want 00001 (ptr=0)", bus_if.gnt);
        end
        tick();
        $display("txn async reset mid-stall done");
    endtask

    task automatic test_random();
        logic [4:0] g_exp;
        for (int n = 0; n < 300; n++) begin
            bus_if.req = 5'($urandom_range(0, 31));
            bus_if.ret = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) set_din(i, 8'($urandom_range(0, 255)));
            #1;
            g_exp = exp_gnt();
            checks++;
            if (bus_if.gnt !== g_exp) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", n, bus_if.gnt, g_exp);
            end
            tick();
            checks++;
            if (bus_if.val !== val_m || (val_m && bus_if.Data_out !== data_m)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got val=%b data=%h want val=%b data=%h",
                         n, bus_if.val, bus_if.Data_out, val_m, data_m);
            end
            $display("txn rand %0d req=%b ret=%b gnt=%b val=%b data=%h",
                     n, bus_if.req, bus_if.ret, g_exp, bus_if.val, bus_if.Data_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus_if.Data_in = '0;
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_wrap_skip();
        test_drain();
        test_ret_idle_and_stall_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
